// File: rtl/ga21_pkg.sv
// Shared types and defaults for the GA21 palette DMA initiator.
// Holds the FSM state type, CPU register indices and default port widths.
package ga21_pkg;

  localparam int DEF_DST_W  = 13;
  localparam int DEF_SRC_W  = 14;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    XFER
  } dma_state_e;

endpackage

// File: rtl/ga21_dma_regs.sv
// CPU-visible register file for the palette DMA: base/length registers,
// control decode, vblank rising-edge detect and the armed-start flag.
module ga21_dma_regs
  import ga21_pkg::*;
#(
  parameter int DST_W = DEF_DST_W,
  parameter int SRC_W = DEF_SRC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_wr,
  input  logic [1:0]       cpu_reg,
  input  logic [15:0]      cpu_din,
  input  logic             vblank,
  input  logic             idle,
  output logic             start,
  output logic [SRC_W-1:0] src_base,
  output logic [DST_W-1:0] dst_base,
  output logic [DST_W-1:0] length
);

  logic vblank_q;
  logic armed;
  logic ctrl_wr;
  logic vblank_rise;
  logic unused_din;

  // Control writes only count while idle; a busy engine ignores them entirely.
  assign ctrl_wr     = cpu_wr && (cpu_reg == REG_CTRL) && idle;
  assign vblank_rise = vblank && !vblank_q;
  assign start       = idle && ((ctrl_wr && cpu_din[0]) || (armed && vblank_rise));
  assign unused_din  = ^cpu_din;

  always_ff @(posedge clk) begin
    if (reset) begin
      vblank_q <= 1'b0;
      armed    <= 1'b0;
      src_base <= '0;
      dst_base <= '0;
      length   <= '0;
    end else begin
      vblank_q <= vblank;
      if (start) begin
        armed <= 1'b0;
      end else if (ctrl_wr && cpu_din[1]) begin
        armed <= 1'b1;
      end
      if (cpu_wr) begin
        case (cpu_reg)
          REG_SRC: src_base <= cpu_din[SRC_W-1:0];
          REG_DST: dst_base <= cpu_din[DST_W-1:0];
          REG_LEN: length   <= cpu_din[DST_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ga21_pal_dma.sv
// Palette DMA initiator: streams colour words from the staging buffer into
// palette RAM, one word per ce cycle after a single prime read.
module ga21_pal_dma
  import ga21_pkg::*;
#(
  parameter int DST_W  = DEF_DST_W,
  parameter int SRC_W  = DEF_SRC_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              vblank,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_reg,
  input  logic [15:0]       cpu_din,
  output logic [SRC_W-1:0]  src_addr,
  output logic              src_rd,
  input  logic [DATA_W-1:0] src_q,
  output logic              ga21_req,
  output logic              ga21_we,
  output logic [DST_W-1:0]  ga21_addr,
  output logic [DATA_W-1:0] ga21_dout,
  output logic              dma_busy,
  output logic              done_irq
);

  dma_state_e       state, state_next;
  logic             start;
  logic [SRC_W-1:0] src_base, src_ptr;
  logic [DST_W-1:0] dst_base, length, dst_ptr;
  logic [DST_W:0]   remaining;
  logic             last_word;

  assign last_word = (remaining == (DST_W+1)'(1));

  ga21_dma_regs #(
    .DST_W(DST_W),
    .SRC_W(SRC_W)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .cpu_wr   (cpu_wr),
    .cpu_reg  (cpu_reg),
    .cpu_din  (cpu_din),
    .vblank   (vblank),
    .idle     (state == IDLE),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .length   (length)
  );

  // A zero length register means a full 2**DST_W word transfer, hence the extra bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      done_irq  <= 1'b0;
    end else begin
      state    <= state_next;
      done_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_base;
            dst_ptr   <= dst_base;
            remaining <= (length == '0) ? {1'b1, {DST_W{1'b0}}} : {1'b0, length};
          end
        end
        PRIME: begin
          if (ce) src_ptr <= src_ptr + SRC_W'(1);
        end
        XFER: begin
          if (ce) begin
            src_ptr   <= src_ptr + SRC_W'(1);
            dst_ptr   <= dst_ptr + DST_W'(1);
            remaining <= remaining - (DST_W+1)'(1);
            if (last_word) done_irq <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    src_rd     = 1'b0;
    src_addr   = '0;
    ga21_req   = 1'b0;
    ga21_we    = 1'b0;
    ga21_addr  = '0;
    ga21_dout  = '0;
    dma_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = PRIME;
      end
      PRIME: begin
        ga21_req = 1'b1;
        dma_busy = 1'b1;
        src_rd   = 1'b1;
        src_addr = src_ptr;
        if (ce) state_next = XFER;
      end
      XFER: begin
        ga21_req  = 1'b1;
        dma_busy  = 1'b1;
        ga21_we   = ce;
        ga21_addr = dst_ptr;
        ga21_dout = src_q;
        src_rd    = (remaining > (DST_W+1)'(1));
        src_addr  = src_ptr;
        if (ce && last_word) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ga21_pal_dma.sv
// Self-checking bench for ga21_pal_dma: directed scenarios plus randomized
// runs, compared each cycle against a transfer-level reference model.
module tb_ga21_pal_dma;

  localparam int DST_W  = 13;
  localparam int SRC_W  = 14;
  localparam int DATA_W = 16;
  localparam int NWORDS = 1 << DST_W;
  localparam int SWORDS = 1 << SRC_W;

  logic              clk = 1'b0;
  logic              reset, ce, vblank, cpu_wr;
  logic [1:0]        cpu_reg;
  logic [15:0]       cpu_din;
  logic [SRC_W-1:0]  src_addr;
  logic              src_rd;
  logic [DATA_W-1:0] src_q = '0;
  logic              ga21_req, ga21_we, dma_busy, done_irq;
  logic [DST_W-1:0]  ga21_addr;
  logic [DATA_W-1:0] ga21_dout;

  logic [DATA_W-1:0] mem [0:SWORDS-1];

  int checks = 0;
  int errors = 0;

  // reference model state (transfer-level view)
  int m_src_b, m_dst_b, m_len_b;
  bit m_armed, m_prev_vb;
  bit exp_busy, exp_done, check_en;
  int left, cur_n, cur_src, cur_dst;
  int obs_busy, obs_we, obs_done;

  ga21_pal_dma dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .vblank    (vblank),
    .cpu_wr    (cpu_wr),
    .cpu_reg   (cpu_reg),
    .cpu_din   (cpu_din),
    .src_addr  (src_addr),
    .src_rd    (src_rd),
    .src_q     (src_q),
    .ga21_req  (ga21_req),
    .ga21_we   (ga21_we),
    .ga21_addr (ga21_addr),
    .ga21_dout (ga21_dout),
    .dma_busy  (dma_busy),
    .done_irq  (done_irq)
  );

  always #5 clk = ~clk;

  // staging buffer: registered read, data valid on the next ce cycle
  always @(posedge clk) if (ce && src_rd) src_q <= mem[src_addr];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_src_b = 0; m_dst_b = 0; m_len_b = 0;
    m_armed = 0; m_prev_vb = 0;
    exp_busy = 0; left = 0;
  endtask

  // one clock: check outputs at negedge, advance model, return at posedge+1
  task automatic step();
    bit vb_rise, start, ctrl_wr, exp_we, exp_rd, next_done;
    int k;
    @(negedge clk);
    if (check_en) begin
      exp_we = exp_busy && ce && (left <= cur_n);
      exp_rd = exp_busy && (left > 1);
      checkOutput("busy", dma_busy, exp_busy);
      checkOutput("req", ga21_req, exp_busy);
      checkOutput("we", ga21_we, exp_we);
      checkOutput("src_rd", src_rd, exp_rd);
      checkOutput("done", done_irq, exp_done);
      if (exp_rd) checkOutput("src_addr", src_addr, (cur_src + cur_n + 1 - left) % SWORDS);
      if (exp_we) begin
        k = cur_n - left;
        checkOutput("wr_addr", ga21_addr, (cur_dst + k) % NWORDS);
        checkOutput("wr_data", ga21_dout, mem[(cur_src + k) % SWORDS]);
      end
      if (!exp_busy) checkOutput("idle_outs", {src_addr, ga21_addr, ga21_dout}, 0);
      if (dma_busy === 1'b1) obs_busy++;
      if (ga21_we === 1'b1) obs_we++;
      if (done_irq === 1'b1) obs_done++;
    end
    next_done = 0;
    if (reset) begin
      modelReset();
    end else begin
      vb_rise = vblank && !m_prev_vb;
      ctrl_wr = cpu_wr && (cpu_reg == 2'd3) && !exp_busy;
      start   = !exp_busy && ((ctrl_wr && cpu_din[0]) || (m_armed && vb_rise));
      if (exp_busy && ce) begin
        left--;
        if (left == 0) begin exp_busy = 0; next_done = 1; end
      end
      if (start) begin
        exp_busy = 1;
        cur_src  = m_src_b;
        cur_dst  = m_dst_b;
        cur_n    = (m_len_b == 0) ? NWORDS : m_len_b;
        left     = cur_n + 1;
        m_armed  = 0;
      end else if (ctrl_wr && cpu_din[1]) begin
        m_armed = 1;
      end
      if (cpu_wr) begin
        case (cpu_reg)
          2'd0: m_src_b = cpu_din % SWORDS;
          2'd1: m_dst_b = cpu_din % NWORDS;
          2'd2: m_len_b = cpu_din % NWORDS;
          default: ;
        endcase
      end
      m_prev_vb = vblank;
    end
    @(posedge clk);
    #1;
    exp_done = next_done;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] v);
    cpu_wr = 1'b1; cpu_reg = r; cpu_din = v;
    step();
    cpu_wr = 1'b0; cpu_din = '0;
  endtask

  task automatic setupRun(input int s, input int d, input int n);
    applyStimulus(2'd0, 16'(s));
    applyStimulus(2'd1, 16'(d));
    applyStimulus(2'd2, 16'(n));
  endtask

  task automatic clearObs();
    obs_busy = 0; obs_we = 0; obs_done = 0;
  endtask

  // mode 0: ce=1, mode 1: ce toggles, mode 2: random ce and vblank
  task automatic runUntilIdle(input int mode, input int budget);
    int n = 0;
    while (exp_busy && n < budget) begin
      case (mode)
        1: ce = ~ce;
        2: begin ce = ($urandom_range(0, 3) != 0); vblank = 1'($urandom_range(0, 1)); end
        default: ce = 1'b1;
      endcase
      step();
      n++;
    end
    if (exp_busy) begin
      checks++; errors++;
      $error("[TB] FAIL run_timeout observed=busy expected=idle within %0d cycles", budget);
    end
    ce = 1'b1; vblank = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; vblank = 1'b0; cpu_wr = 1'b0; cpu_reg = '0; cpu_din = '0;
    check_en = 0; exp_done = 0;
    modelReset();
    clearObs();
    for (int i = 0; i < SWORDS; i++) mem[i] = 16'(16'hA000 + i);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_en = 1;

    // reset state
    step();
    step();

    // 1: immediate 4-word copy
    setupRun(16'h0100, 16'h0010, 4);
    clearObs();
    applyStimulus(2'd3, 16'h0001);
    runUntilIdle(0, 100);
    checkOutput("t1_busy_clks", obs_busy, 5);
    checkOutput("t1_writes", obs_we, 4);
    checkOutput("t1_done", obs_done, 1);

    // 2: vblank-armed start, no retrigger
    setupRun(16'h0200, 16'h0100, 3);
    applyStimulus(2'd3, 16'h0002);
    clearObs();
    repeat (5) step();
    checkOutput("t2_no_early", obs_busy, 0);
    vblank = 1'b1;
    step();
    checkOutput("t2_edge_clk", obs_busy, 0);
    step();
    checkOutput("t2_start_lat", obs_busy, 1);
    runUntilIdle(0, 100);
    checkOutput("t2_writes", obs_we, 3);
    step();
    vblank = 1'b1;
    clearObs();
    repeat (6) step();
    checkOutput("t2_no_retrig", obs_busy, 0);
    vblank = 1'b0;

    // 3: destination and source wrap
    setupRun(16'h3FFF, 16'h1FFE, 4);
    clearObs();
    applyStimulus(2'd3, 16'h0001);
    runUntilIdle(0, 100);
    checkOutput("t3_writes", obs_we, 4);

    // 4: ce toggling
    setupRun(16'h0050, 16'h0400, 5);
    clearObs();
    applyStimulus(2'd3, 16'h0001);
    runUntilIdle(1, 100);
    checkOutput("t4_writes", obs_we, 5);
    checkOutput("t4_done", obs_done, 1);

    // 5: full-length transfer with ignored ctrl and deferred dst write
    setupRun(16'h1234, 16'h0040, 0);
    clearObs();
    applyStimulus(2'd3, 16'h0001);
    repeat (10) step();
    applyStimulus(2'd3, 16'h0003);
    applyStimulus(2'd1, 16'h0700);
    runUntilIdle(0, 9000);
    checkOutput("t5_writes", obs_we, NWORDS);
    checkOutput("t5_done", obs_done, 1);
    vblank = 1'b1;
    clearObs();
    repeat (4) step();
    checkOutput("t5_not_armed", obs_busy, 0);
    vblank = 1'b0;
    step();
    applyStimulus(2'd2, 16'h0003);
    clearObs();
    applyStimulus(2'd3, 16'h0001);
    runUntilIdle(0, 100);
    checkOutput("t5_next_writes", obs_we, 3);

    // 6: reset mid-transfer aborts silently
    setupRun(16'h0020, 16'h0300, 10);
    applyStimulus(2'd3, 16'h0001);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clearObs();
    repeat (3) step();
    checkOutput("t6_busy_after", obs_busy, 0);
    checkOutput("t6_no_done", obs_done, 0);
    setupRun(16'h0600, 16'h0123, 3);
    clearObs();
    applyStimulus(2'd3, 16'h0001);
    runUntilIdle(0, 100);
    checkOutput("t6_restart", obs_we, 3);

    // randomized runs
    for (int i = 0; i < SWORDS; i++) mem[i] = 16'($urandom);
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 24);
      setupRun($urandom_range(0, SWORDS - 1), $urandom_range(0, NWORDS - 1), n);
      clearObs();
      if ($urandom_range(0, 1) == 1) begin
        applyStimulus(2'd3, 16'h0002);
        repeat ($urandom_range(0, 4)) step();
        vblank = 1'b1;
        step();
      end else begin
        applyStimulus(2'd3, 16'h0001);
      end
      runUntilIdle(2, 1000);
      checkOutput("rnd_writes", obs_we, n);
      checkOutput("rnd_done", obs_done, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
